// File: rtl/load_run_ctrl_pkg.sv
// Shared types and widths for the load/run controller.
// Holds the controller state enum and the address, data and counter widths.
package load_run_ctrl_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_LAUNCH,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/load_run_ctrl_sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at all-ones.
// Ports: clk, rst (async high), clear, enable, count[W-1:0].
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/load_run_ctrl.sv
// Loads a byte stream into the core's data RAM, then launches and times a run.
// Ports: CLK, start (async reset), ld_* loader stream, go/halt, cpu_start,
// mem_* RAM write port, busy/done/timeout/load_ovf flags, cycle_count.
module load_run_ctrl
    import load_run_ctrl_pkg::*;
#(
    parameter int                LAUNCH_CYC = 2,
    parameter logic [CNT_W-1:0]  TIMEOUT    = 16'd4096
) (
    input  logic              CLK,
    input  logic              start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              go,
    input  logic              halt,
    output logic              cpu_start,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              load_ovf,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int LW = (LAUNCH_CYC > 1) ? $clog2(LAUNCH_CYC) : 1;
    localparam logic [LW-1:0] LCNT_LAST = LW'(LAUNCH_CYC - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LW-1:0]     lcnt_q, lcnt_d;
    logic              cpu_start_q, cpu_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              load_ovf_q, load_ovf_d;
    logic              cnt_clear, cnt_en;
    logic              launch;
    logic              hs;
    logic              to_hit;

    assign ld_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign hs        = ld_valid && ld_ready;
    assign mem_we    = hs;
    assign mem_addr  = ptr_q;
    assign mem_wdata = ld_data;
    assign to_hit    = (TIMEOUT != '0) && (cycle_count == TIMEOUT);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        lcnt_d      = lcnt_q;
        cpu_start_d = cpu_start_q;
        busy_d      = busy_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        load_ovf_d  = load_ovf_q;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;
        launch      = 1'b0;

        // Shared byte-accept path for IDLE and LOAD; a load beats go.
        if (hs) begin
            ptr_d = ptr_q + ADDR_W'(1);
            if ((ptr_q == '1) && !ld_last) begin
                load_ovf_d = 1'b1;
            end
            if (ld_last) begin
                ptr_d   = '0;
                state_d = ST_IDLE;
            end else begin
                state_d = ST_LOAD;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (!hs && go) begin
                    launch = 1'b1;
                end
            end
            ST_LOAD: begin
            end
            ST_LAUNCH: begin
                if (lcnt_q == LCNT_LAST) begin
                    state_d     = ST_RUN;
                    cpu_start_d = 1'b0;
                end else begin
                    lcnt_d = lcnt_q + LW'(1);
                end
            end
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (to_hit) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                if (go) begin
                    launch = 1'b1;
                end else if (ld_valid) begin
                    // Leave for the loader; the byte is not taken here.
                    state_d     = ST_IDLE;
                    cpu_start_d = 1'b1;
                    done_d      = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (launch) begin
            state_d     = ST_LAUNCH;
            lcnt_d      = '0;
            cpu_start_d = 1'b1;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            timeout_d   = 1'b0;
            cnt_clear   = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge start) begin
        if (start) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            lcnt_q      <= '0;
            cpu_start_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            load_ovf_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            lcnt_q      <= lcnt_d;
            cpu_start_q <= cpu_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            load_ovf_q  <= load_ovf_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk    (CLK),
        .rst    (start),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (cycle_count)
    );

    assign cpu_start = cpu_start_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign load_ovf  = load_ovf_q;

endmodule

// File: tb/tb_load_run_ctrl.sv
// Scoreboard bench for load_run_ctrl: RAM writes and run results are queued
// by the stimulus and popped by a monitor when the DUT presents them.
module tb_load_run_ctrl;

    logic        CLK = 1'b0;
    logic        start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = 8'h00;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic        go = 1'b0;
    logic        halt = 1'b0;
    logic        cpu_start;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        load_ovf;
    logic [15:0] cycle_count;

    always #5 CLK = ~CLK;

    load_run_ctrl #(
        .LAUNCH_CYC (2),
        .TIMEOUT    (16'd16)
    ) dut (
        .CLK         (CLK),
        .start       (start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .ld_ready    (ld_ready),
        .go          (go),
        .halt        (halt),
        .cpu_start   (cpu_start),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .load_ovf    (load_ovf),
        .cycle_count (cycle_count)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct packed {
        logic [15:0] cnt;
        logic        to;
    } run_t;

    wr_t  exp_wr[$];
    run_t exp_run[$];
    wr_t  mon_w;
    run_t mon_r;
    logic done_prev = 1'b0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    task automatic push_run(input logic [15:0] c, input logic t);
        run_t r;
        r.cnt = c;
        r.to  = t;
        exp_run.push_back(r);
    endtask

    task automatic launch_run();
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("launch1_cpu_start", cpu_start, 1);
        chk("launch1_busy", busy, 1);
        chk("launch1_ld_ready", ld_ready, 0);
        chk("launch_count_clr", cycle_count, 0);
        chk("launch_done_clr", done, 0);
        tick();
        chk("launch2_cpu_start", cpu_start, 1);
        tick();
        chk("run_cpu_start", cpu_start, 0);
        chk("run_busy", busy, 1);
    endtask

    // Monitor: compare each RAM write and each run completion.
    always @(negedge CLK) begin
        if (mem_we === 1'b1) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h",
                         mem_addr, mem_wdata);
            end else begin
                mon_w = exp_wr.pop_front();
                chk("wr_addr", mem_addr, mon_w.addr);
                chk("wr_data", mem_wdata, mon_w.data);
            end
        end
        if ((done === 1'b1) && !done_prev) begin
            if (exp_run.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: count %0d", cycle_count);
            end else begin
                mon_r = exp_run.pop_front();
                chk("run_count", cycle_count, mon_r.cnt);
                chk("run_timeout", timeout, mon_r.to);
            end
        end
        done_prev = (done === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [7:0] b;

        #1 start = 1'b1;
        #10;
        chk("rst_cpu_start", cpu_start, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_load_ovf", load_ovf, 0);
        chk("rst_count", cycle_count, 0);
        chk("rst_ld_ready", ld_ready, 1);
        tick();
        start = 1'b0;
        tick();

        // Three-byte burst, then a single byte proves ptr returned to 0.
        push_wr(8'd0, 8'hA1);
        push_wr(8'd1, 8'hB2);
        push_wr(8'd2, 8'hC3);
        ld_valid = 1'b1;
        ld_data  = 8'hA1;
        tick();
        ld_data = 8'hB2;
        tick();
        ld_data = 8'hC3;
        ld_last = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("burst_idle_ready", ld_ready, 1);
        chk("burst_idle_busy", busy, 0);
        push_wr(8'd0, 8'hD4);
        ld_valid = 1'b1;
        ld_data  = 8'hD4;
        ld_last  = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        tick();

        // Halt raised once 10 cycles have been counted.
        push_run(16'd10, 1'b0);
        launch_run();
        repeat (10) tick();
        chk("run10_count", cycle_count, 10);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_done", done, 1);
        chk("halt_busy", busy, 0);
        chk("halt_cpu_start", cpu_start, 0);
        repeat (3) tick();
        chk("done_frozen", cycle_count, 10);

        // Timeout with no halt: DONE on the 17th RUN cycle.
        push_run(16'd16, 1'b1);
        launch_run();
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("to_reached", done, 1);
        chk("to_latency", n, 17);

        // Halt in the same cycle the limit is reached wins.
        push_run(16'd16, 1'b0);
        launch_run();
        repeat (16) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("tie_done", done, 1);

        // ld_valid in DONE returns to IDLE without taking the byte.
        ld_valid = 1'b1;
        ld_data  = 8'h55;
        #1;
        chk("done_ld_ready", ld_ready, 0);
        chk("done_mem_we", mem_we, 0);
        tick();
        ld_valid = 1'b0;
        chk("back_idle_ready", ld_ready, 1);
        chk("back_idle_cpu_start", cpu_start, 1);
        tick();

        // go together with an IDLE handshake is dropped.
        push_wr(8'd0, 8'h77);
        ld_valid = 1'b1;
        ld_data  = 8'h77;
        ld_last  = 1'b1;
        go       = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        go       = 1'b0;
        chk("go_drop_busy", busy, 0);
        chk("go_drop_ready", ld_ready, 1);
        tick();
        chk("go_not_queued", busy, 0);

        // 257-byte burst wraps the pointer; go mid-burst is ignored.
        for (int i = 0; i < 257; i++) begin
            b        = 8'(i);
            ld_valid = 1'b1;
            ld_data  = b ^ 8'h5A;
            ld_last  = (i == 256);
            go       = (i == 10);
            push_wr(b, b ^ 8'h5A);
            if (i == 255) chk("ovf_before", load_ovf, 0);
            tick();
            if (i == 10) chk("load_go_ignored", busy, 0);
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        go       = 1'b0;
        chk("ovf_set", load_ovf, 1);
        chk("wrap_idle_ready", ld_ready, 1);
        push_wr(8'd0, 8'hEE);
        ld_valid = 1'b1;
        ld_data  = 8'hEE;
        ld_last  = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk("ovf_sticky", load_ovf, 1);
        tick();

        // Reset in the middle of a run.
        launch_run();
        repeat (5) tick();
        chk("run5_count", cycle_count, 5);
        start = 1'b1;
        #1;
        chk("mid_rst_cpu_start", cpu_start, 1);
        chk("mid_rst_count", cycle_count, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", ld_ready, 1);
        chk("mid_rst_ovf", load_ovf, 0);
        tick();
        start = 1'b0;
        tick();

        // Two back-to-back runs; the second launched from DONE.
        push_run(16'd3, 1'b0);
        launch_run();
        repeat (3) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        push_run(16'd7, 1'b0);
        launch_run();
        repeat (7) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("rerun_done", done, 1);

        repeat (3) tick();
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("run_queue_empty", exp_run.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
